// File: rtl/fmul_arbiter.sv
// Two-port arbiter in front of a shared combinational FP32 multiplier, with a tagged result
// pipeline and per-port credit-protected response FIFOs. Define FMUL_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module fmul_arbiter #(
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned RESP_DEPTH  = 2
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             flush_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [31:0]      req0_rs1_i,
    input  logic [31:0]      req0_rs2_i,
    input  logic [2:0]       req0_rm_i,
    input  logic [TAG_W-1:0] req0_tag_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [31:0]      req1_rs1_i,
    input  logic [31:0]      req1_rs2_i,
    input  logic [2:0]       req1_rm_i,
    input  logic [TAG_W-1:0] req1_tag_i,
    output logic             resp0_valid_o,
    input  logic             resp0_ready_i,
    output logic [31:0]      resp0_result_o,
    output logic [5:0]       resp0_class_o,
    output logic [TAG_W-1:0] resp0_tag_o,
    output logic             resp1_valid_o,
    input  logic             resp1_ready_i,
    output logic [31:0]      resp1_result_o,
    output logic [5:0]       resp1_class_o,
    output logic [TAG_W-1:0] resp1_tag_o,
    output logic [31:0]      mul_rs1_o,
    output logic [31:0]      mul_rs2_o,
    output logic [2:0]       mul_rm_o,
    input  logic [31:0]      mul_result_i,
    input  logic [5:0]       mul_class_i,
    output logic             busy_o
);
    localparam int unsigned CRED_W = 3;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned SLOTS  = 4;
    localparam int unsigned DW     = TAG_W + 38;
    localparam int unsigned EW     = DW + 1;
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RESP_DEPTH);

    logic [CRED_W-1:0] r_credit [2];
    logic [1:0]        w_elig, w_gnt, w_push, w_pop, w_resp_valid, w_resp_ready;
    logic              r_s0_valid, r_s0_port;
    logic [TAG_W-1:0]  r_s0_tag;
    logic [EW-1:0]     w_cap_data, w_push_data;
    logic              w_push_valid, w_pipe_busy;
    logic [DW-1:0]     r_mem [2][SLOTS];
    logic [PTR_W-1:0]  r_rd [2];
    logic [PTR_W-1:0]  r_wr [2];
    logic [CRED_W-1:0] r_cnt [2];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A port may issue only when it holds a credit for a guaranteed FIFO slot.
    assign w_elig[0] = resetn_i & ~flush_i & req0_valid_i & (r_credit[0] != '0);
    assign w_elig[1] = resetn_i & ~flush_i & req1_valid_i & (r_credit[1] != '0);

`ifdef FMUL_ARB_FIXED_PRIO_EN
    always_comb begin
        w_gnt = 2'b00;
        if (w_elig[0])      w_gnt = 2'b01;
        else if (w_elig[1]) w_gnt = 2'b10;
    end
`else
    logic r_last_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (&w_elig) w_gnt = r_last_gnt ? 2'b01 : 2'b10;
        else         w_gnt = w_elig;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i)   r_last_gnt <= 1'b1;
        else if (|w_gnt) r_last_gnt <= w_gnt[1];
    end
`endif

    assign req0_ready_o = w_gnt[0];
    assign req1_ready_o = w_gnt[1];

    // Issue stage: operands drive the multiplier, {port, tag} ride alongside.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_s0_valid <= 1'b0;
            r_s0_port  <= 1'b0;
            r_s0_tag   <= '0;
            mul_rs1_o  <= '0;
            mul_rs2_o  <= '0;
            mul_rm_o   <= '0;
        end else begin
            r_s0_valid <= |w_gnt;
            if (|w_gnt) begin
                r_s0_port <= w_gnt[1];
                r_s0_tag  <= w_gnt[1] ? req1_tag_i : req0_tag_i;
                mul_rs1_o <= w_gnt[1] ? req1_rs1_i : req0_rs1_i;
                mul_rs2_o <= w_gnt[1] ? req1_rs2_i : req0_rs2_i;
                mul_rm_o  <= w_gnt[1] ? req1_rm_i  : req0_rm_i;
            end
        end
    end

    assign w_cap_data = {r_s0_port, r_s0_tag, mul_result_i, mul_class_i};

    generate
        if (PIPE_STAGES == 0) begin : g_no_pipe
            assign w_push_valid = r_s0_valid;
            assign w_push_data  = w_cap_data;
            assign w_pipe_busy  = 1'b0;
        end else begin : g_pipe
            logic [PIPE_STAGES-1:0] r_pv;
            logic [EW-1:0]          r_pd [PIPE_STAGES];

            always_ff @(posedge clk_i or negedge resetn_i) begin
                if (!resetn_i) begin
                    r_pv <= '0;
                    for (int k = 0; k < int'(PIPE_STAGES); k++) r_pd[k] <= '0;
                end else begin
                    r_pv[0] <= r_s0_valid & ~flush_i;
                    r_pd[0] <= w_cap_data;
                    for (int k = 1; k < int'(PIPE_STAGES); k++) begin
                        r_pv[k] <= r_pv[k-1] & ~flush_i;
                        r_pd[k] <= r_pd[k-1];
                    end
                end
            end

            assign w_push_valid = r_pv[PIPE_STAGES-1];
            assign w_push_data  = r_pd[PIPE_STAGES-1];
            assign w_pipe_busy  = |r_pv;
        end
    endgenerate

    assign w_resp_ready = {resp1_ready_i, resp0_ready_i};
    assign w_resp_valid = {(r_cnt[1] != '0), (r_cnt[0] != '0)};
    assign w_pop        = w_resp_valid & w_resp_ready & {2{~flush_i}};
    assign w_push[0]    = w_push_valid & ~flush_i & ~w_push_data[EW-1];
    assign w_push[1]    = w_push_valid & ~flush_i &  w_push_data[EW-1];

    // Response FIFOs and credits; credits mirror free FIFO slots minus in-flight issues.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int p = 0; p < 2; p++) begin
                r_rd[p]     <= '0;
                r_wr[p]     <= '0;
                r_cnt[p]    <= '0;
                r_credit[p] <= CRED_MAX;
                for (int s = 0; s < int'(SLOTS); s++) r_mem[p][s] <= '0;
            end
        end else if (flush_i) begin
            for (int p = 0; p < 2; p++) begin
                r_rd[p]     <= '0;
                r_wr[p]     <= '0;
                r_cnt[p]    <= '0;
                r_credit[p] <= CRED_MAX;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_push[p]) begin
                    r_mem[p][r_wr[p]] <= w_push_data[DW-1:0];
                    r_wr[p]           <= ptr_inc(r_wr[p]);
                end
                if (w_pop[p]) r_rd[p] <= ptr_inc(r_rd[p]);
                r_cnt[p]    <= r_cnt[p] + CRED_W'(w_push[p]) - CRED_W'(w_pop[p]);
                r_credit[p] <= r_credit[p] - CRED_W'(w_gnt[p]) + CRED_W'(w_pop[p]);
            end
        end
    end

    assign resp0_valid_o = w_resp_valid[0];
    assign resp1_valid_o = w_resp_valid[1];
    assign {resp0_tag_o, resp0_result_o, resp0_class_o} = r_mem[0][r_rd[0]];
    assign {resp1_tag_o, resp1_result_o, resp1_class_o} = r_mem[1][r_rd[1]];

    assign busy_o = r_s0_valid | w_pipe_busy | (|w_resp_valid);
endmodule

// File: tb/tb_fmul_arbiter.sv
// Randomized scoreboard bench for fmul_arbiter: a transaction-level model predicts grants,
// multiplier operands and per-port response order/timing; a monitor pops and compares.
`timescale 1ns/1ps
module tb_fmul_arbiter;
    localparam int unsigned TAG_W       = 4;
    localparam int unsigned PIPE_STAGES = 1;
    localparam int unsigned RESP_DEPTH  = 2;
    localparam int          LAT         = 2 + int'(PIPE_STAGES);
    localparam logic [5:0]  CLS_ZERO    = 6'b000001;
    localparam logic [5:0]  CLS_NORM    = 6'b000010;

    logic             clk = 1'b0, resetn = 1'b0, flush = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
    logic [31:0]      req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
    logic [2:0]       req0_rm = '0, req1_rm = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic             resp0_valid, resp1_valid, resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [31:0]      resp0_result, resp1_result, mul_rs1, mul_rs2, mul_result;
    logic [5:0]       resp0_class, resp1_class, mul_class;
    logic [TAG_W-1:0] resp0_tag, resp1_tag;
    logic [2:0]       mul_rm;
    logic             busy;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        logic [5:0]       cls;
        int               vis;
    } exp_t;

    exp_t        q0[$], q1[$];
    int          cyc = 0, n_checks = 0, n_fail = 0, m_issue0 = 0;
    logic        m_last = 1'b1, pop0 = 1'b0, pop1 = 1'b0;
    logic [1:0]  m_gnt = 2'b00;
    logic [31:0] ex_rs1 = '0, ex_rs2 = '0;
    logic [2:0]  ex_rm = '0;

    // Truncating FP32 multiply stub; rm is folded into the LSBs so its routing is observable.
    function automatic logic [37:0] fmul_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        logic [47:0] prod;
        logic [9:0]  e;
        logic [22:0] m;
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e    = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (prod[47]) begin
            m = prod[46:24];
            e = e + 10'd1;
        end else begin
            m = prod[45:23];
        end
        return {({a[31] ^ b[31], e[7:0], m} ^ {29'd0, rm}),
                ((a[30:23] == 8'd0 || b[30:23] == 8'd0) ? CLS_ZERO : CLS_NORM)};
    endfunction

    assign {mul_result, mul_class} = fmul_ref(mul_rs1, mul_rs2, mul_rm);

    fmul_arbiter #(.TAG_W(TAG_W), .PIPE_STAGES(PIPE_STAGES), .RESP_DEPTH(RESP_DEPTH)) dut (
        .clk_i(clk), .resetn_i(resetn), .flush_i(flush),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_rs1_i(req0_rs1),
        .req0_rs2_i(req0_rs2), .req0_rm_i(req0_rm), .req0_tag_i(req0_tag),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_rs1_i(req1_rs1),
        .req1_rs2_i(req1_rs2), .req1_rm_i(req1_rm), .req1_tag_i(req1_tag),
        .resp0_valid_o(resp0_valid), .resp0_ready_i(resp0_ready), .resp0_result_o(resp0_result),
        .resp0_class_o(resp0_class), .resp0_tag_o(resp0_tag),
        .resp1_valid_o(resp1_valid), .resp1_ready_i(resp1_ready), .resp1_result_o(resp1_result),
        .resp1_class_o(resp1_class), .resp1_tag_o(resp1_tag),
        .mul_rs1_o(mul_rs1), .mul_rs2_o(mul_rs2), .mul_rm_o(mul_rm),
        .mul_result_i(mul_result), .mul_class_i(mul_class), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [TAG_W-1:0] t, input logic [31:0] a,
                                input logic [31:0] b, input logic [2:0] rm);
        exp_t e;
        {e.res, e.cls} = fmul_ref(a, b, rm);
        e.tag = t;
        e.vis = cyc + LAT;
        return e;
    endfunction

    // Reference model: credits = depth minus outstanding results; grant per arbitration rule.
    always @(negedge clk) begin
        int  c0, c1;
        logic e0, e1;
        #1;
        if (!resetn) begin
            m_last = 1'b1;
            ex_rs1 = '0;
            ex_rs2 = '0;
            ex_rm  = '0;
        end
        chk("mul_rs1", 64'(mul_rs1), 64'(ex_rs1));
        chk("mul_rs2", 64'(mul_rs2), 64'(ex_rs2));
        chk("mul_rm",  64'(mul_rm),  64'(ex_rm));
        m_gnt = 2'b00;
        if (!resetn || flush) begin
            q0.delete();
            q1.delete();
        end else begin
            c0 = int'(RESP_DEPTH) - q0.size() - int'(pop0);
            c1 = int'(RESP_DEPTH) - q1.size() - int'(pop1);
            e0 = req0_valid && (c0 > 0);
            e1 = req1_valid && (c1 > 0);
`ifdef FMUL_ARB_FIXED_PRIO_EN
            if (e0 && e1) m_gnt = 2'b01;
`else
            if (e0 && e1) m_gnt = m_last ? 2'b01 : 2'b10;
`endif
            else m_gnt = {e1, e0};
            if (m_gnt != 2'b00) m_last = m_gnt[1];
            if (m_gnt[0]) begin
                q0.push_back(mk(req0_tag, req0_rs1, req0_rs2, req0_rm));
                {ex_rs1, ex_rs2, ex_rm} = {req0_rs1, req0_rs2, req0_rm};
                m_issue0 = cyc;
            end
            if (m_gnt[1]) begin
                q1.push_back(mk(req1_tag, req1_rs1, req1_rs2, req1_rm));
                {ex_rs1, ex_rs2, ex_rm} = {req1_rs1, req1_rs2, req1_rm};
            end
        end
        chk("req0_ready", 64'(req0_ready), 64'(m_gnt[0]));
        chk("req1_ready", 64'(req1_ready), 64'(m_gnt[1]));
    end

    task automatic mon_port(input int p, input logic v, input logic [31:0] r, input logic [5:0] c,
                            input logic [TAG_W-1:0] t, input logic rdy, output logic pop);
        exp_t h;
        int   n;
        logic ev;
        n   = (p == 0) ? q0.size() : q1.size();
        ev  = 1'b0;
        pop = 1'b0;
        if (n > 0) begin
            if (p == 0) h = q0[0];
            else        h = q1[0];
            ev = resetn && (h.vis <= cyc);
        end
        chk($sformatf("resp%0d_valid", p), 64'(v), 64'(ev));
        if (v && ev) begin
            chk($sformatf("resp%0d_result", p), 64'(r), 64'(h.res));
            chk($sformatf("resp%0d_class", p),  64'(c), 64'(h.cls));
            chk($sformatf("resp%0d_tag", p),    64'(t), 64'(h.tag));
            if (rdy && !flush) begin
                pop = 1'b1;
                if (p == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    // Monitor: compares FIFO heads and busy against the scoreboard queues.
    always @(negedge clk) begin
        logic busy_ex;
        busy_ex = resetn && ((q0.size() + q1.size()) > 0);
        chk("busy", 64'(busy), 64'(busy_ex));
        mon_port(0, resp0_valid, resp0_result, resp0_class, resp0_tag, resp0_ready, pop0);
        mon_port(1, resp1_valid, resp1_result, resp1_class, resp1_tag, resp1_ready, pop1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random traffic; payloads are held while valid and not yet accepted.
    task automatic run(input int n, input int pv0, input int pv1, input int pr0, input int pr1, input int pfl);
        for (int i = 0; i < n; i++) begin
            if (!req0_valid || m_gnt[0]) begin
                req0_valid = ($urandom_range(99) < pv0);
                req0_rs1 = $urandom; req0_rs2 = $urandom;
                req0_rm = 3'($urandom); req0_tag = TAG_W'($urandom);
            end
            if (!req1_valid || m_gnt[1]) begin
                req1_valid = ($urandom_range(99) < pv1);
                req1_rs1 = $urandom; req1_rs2 = $urandom;
                req1_rm = 3'($urandom); req1_tag = TAG_W'($urandom);
            end
            resp0_ready = ($urandom_range(99) < pr0);
            resp1_ready = ($urandom_range(99) < pr1);
            flush       = ($urandom_range(999) < pfl);
            step();
        end
        flush = 1'b0;
    endtask

    initial begin
        int got;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        step();

        // Single issue: 1.5 * 2.0, tag 3
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req0_valid = 1'b1; req0_rs1 = 32'h3FC0_0000; req0_rs2 = 32'h4000_0000;
        req0_rm = 3'd0; req0_tag = TAG_W'(3);
        for (int i = 0; i < 8 && !m_gnt[0]; i++) step();
        req0_valid = 1'b0;
        got = -1;
        for (int i = 0; i < 12; i++) begin
            if (resp0_valid && got < 0) begin
                got = cyc;
                chk("single_result", 64'(resp0_result), 64'h4040_0000);
                chk("single_class",  64'(resp0_class),  64'(CLS_NORM));
                chk("single_tag",    64'(resp0_tag),    64'd3);
            end
            step();
        end
        chk("single_latency", 64'(got), 64'(m_issue0 + LAT));

        run(40, 100, 100, 100, 100, 0);           // contention
        run(12, 100, 50, 0, 100, 0);              // port 0 backpressure
        run(10, 100, 50, 100, 100, 0);

        run(3, 100, 100, 0, 0, 0);                // flush with results in flight and buffered
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        run(12, 50, 50, 100, 100, 0);

        run(3000, 60, 60, 70, 70, 8);             // random mix

        run(3, 100, 100, 0, 0, 0);                // reset mid-operation
        resetn = 1'b0;
        step();
        chk("rst_resp0_valid", 64'(resp0_valid), 64'd0);
        chk("rst_resp1_valid", 64'(resp1_valid), 64'd0);
        chk("rst_req0_ready",  64'(req0_ready),  64'd0);
        chk("rst_busy",        64'(busy),        64'd0);
        resetn = 1'b1;
        run(30, 100, 100, 100, 100, 0);

        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int i = 0; i < 100 && (q0.size() + q1.size()) > 0; i++) step();
        step();
        chk("drain_empty", 64'(q0.size() + q1.size()), 64'd0);
        chk("drain_busy",  64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
